// File: rtl/dirty_block_scanner_if.sv
// Handshake/bus bundle for the dirty block scanner: scan request on the
// controller side, one {index, address, one-hot} record per set bit on the output side.
interface dirty_block_scanner_if #(
  parameter int NUM_BLOCKS = 128,
  parameter int IDX_W      = 7,
  parameter int OFFSET_W   = 4,
  parameter int ADDR_W     = 16
);
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

  logic                  start;
  logic [NUM_BLOCKS-1:0] mask_in;
  logic [TAG_W-1:0]      tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_idx;
  logic [ADDR_W-1:0]     out_addr;
  logic [NUM_BLOCKS-1:0] out_onehot;
  logic                  busy;
  logic                  done;
  logic [IDX_W:0]        count;

  modport master (
    output start, mask_in, tag_in, out_ready,
    input  out_valid, out_idx, out_addr, out_onehot, busy, done, count
  );

  modport slave (
    input  start, mask_in, tag_in, out_ready,
    output out_valid, out_idx, out_addr, out_onehot, busy, done, count
  );
endinterface

// File: rtl/dirty_block_scanner.sv
// Walks a captured block mask lowest-index first and emits one encoded record
// per set bit, used to sequence cache flush/writeback toward memory.
module dirty_block_scanner #(
  parameter int NUM_BLOCKS = 128,
  parameter int IDX_W      = 7,
  parameter int OFFSET_W   = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dirty_block_scanner_if.slave  bus
);
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_BLOCKS-1:0] mask_q, mask_d;
  logic [NUM_BLOCKS-1:0] onehot_q, onehot_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [IDX_W:0]        count_q, count_d;
  logic [IDX_W-1:0]      enc_idx;
  logic                  mask_empty;

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    enc_idx = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (mask_q[i]) enc_idx = IDX_W'(i);
    end
  end

  assign mask_empty = (mask_q == '0);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    mask_d   = mask_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    onehot_d = onehot_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.mask_in;
          tag_d   = bus.tag_in;
          count_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask_empty) begin
          state_d = S_DONE;
        end else begin
          idx_d    = enc_idx;
          addr_d   = {tag_q, enc_idx, {OFFSET_W{1'b0}}};
          onehot_d = NUM_BLOCKS'(1) << enc_idx;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        // The held one-hot is exactly the bit to retire from the mask.
        if (bus.out_ready) begin
          mask_d  = mask_q & ~onehot_q;
          count_d = count_q + (IDX_W + 1)'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      onehot_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      onehot_q <= onehot_d;
      count_q  <= count_d;
    end
  end

  assign bus.out_valid  = (state_q == S_EMIT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.out_idx    = idx_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_onehot = onehot_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_dirty_block_scanner.sv
// Directed bench for dirty_block_scanner: reset, sparse/empty/full masks,
// back-pressure, start while busy and reset mid-scan.
module tb_dirty_block_scanner;
  localparam int NB = 128;
  localparam int IW = 7;
  localparam int OW = 4;
  localparam int AW = 16;
  localparam int TW = AW - IW - OW;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  int              rec_idx[$];
  logic [AW-1:0]   rec_addr[$];
  logic [NB-1:0]   rec_oh[$];
  logic            busy_e0;

  dirty_block_scanner_if #(.NUM_BLOCKS(NB), .IDX_W(IW), .OFFSET_W(OW), .ADDR_W(AW)) bus ();

  dirty_block_scanner #(.NUM_BLOCKS(NB), .IDX_W(IW), .OFFSET_W(OW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts a scan with out_ready high and logs every record until done.
  // If inject_edge > 0, a second start with inj_mask is raised after that edge.
  task automatic run_scan(input logic [NB-1:0] m, input logic [TW-1:0] t,
                          input int inject_edge, input logic [NB-1:0] inj_mask,
                          output int done_edge);
    rec_idx.delete();
    rec_addr.delete();
    rec_oh.delete();
    done_edge = -1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mask_in   = m;
    bus.tag_in    = t;
    bus.out_ready = 1'b1;
    step();
    busy_e0     = bus.busy;
    bus.start   = 1'b0;
    bus.mask_in = ~m;
    bus.tag_in  = ~t;
    for (int n = 1; n <= 400; n++) begin
      step();
      if (bus.out_valid) begin
        rec_idx.push_back(int'(bus.out_idx));
        rec_addr.push_back(bus.out_addr);
        rec_oh.push_back(bus.out_onehot);
      end
      if (n == inject_edge) begin
        bus.start   = 1'b1;
        bus.mask_in = inj_mask;
        bus.tag_in  = ~t;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_edge = n;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.out_idx !== '0 || bus.out_addr !== '0 || bus.out_onehot !== '0 || bus.count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b idx=%0d addr=%h oh=%h count=%0d, all expected 0",
               bus.out_valid, bus.busy, bus.done, bus.out_idx, bus.out_addr, bus.out_onehot, bus.count);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: busy=%b valid=%b done=%b, expected 0 0 0",
                 c, bus.busy, bus.out_valid, bus.done);
      end
    end
  endtask

  task automatic test_sparse();
    logic [NB-1:0] m;
    logic [NB-1:0] one;
    int            exp_idx[3];
    logic [AW-1:0] exp_addr[3];
    int            de;
    exp_idx  = '{3, 64, 127};
    exp_addr = '{16'hA830, 16'hAC00, 16'hAFF0};
    one = 1;
    m   = '0;
    m[3] = 1'b1; m[64] = 1'b1; m[127] = 1'b1;
    run_scan(m, 5'h15, 0, '0, de);
    checks++;
    if (busy_e0 !== 1'b1) begin
      errors++;
      $display("FAIL sparse_busy_after_e0: got %b, expected 1", busy_e0);
    end
    checks++;
    if (rec_idx.size() != 3) begin
      errors++;
      $display("FAIL sparse_record_count: got %0d records, expected 3", rec_idx.size());
    end
    for (int i = 0; i < 3 && i < rec_idx.size(); i++) begin
      checks++;
      if (rec_idx[i] != exp_idx[i] || rec_addr[i] !== exp_addr[i] || rec_oh[i] !== (one << exp_idx[i])) begin
        errors++;
        $display("FAIL sparse_record %0d: idx=%0d addr=%h oh=%h, expected idx=%0d addr=%h",
                 i, rec_idx[i], rec_addr[i], rec_oh[i], exp_idx[i], exp_addr[i]);
      end
    end
    checks++;
    if (de != 7 || bus.count !== 8'd3) begin
      errors++;
      $display("FAIL sparse_done: done edge=%0d count=%0d, expected edge 7 count 3", de, bus.count);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 8'd3) begin
      errors++;
      $display("FAIL sparse_after_done: busy=%b done=%b count=%0d, expected 0 0 3", bus.busy, bus.done, bus.count);
    end
  endtask

  task automatic test_back_pressure();
    logic [NB-1:0] m;
    bit            seen_done;
    m = '0;
    m[10] = 1'b1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mask_in   = m;
    bus.tag_in    = 5'h03;
    bus.out_ready = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 7'd10 || bus.out_onehot !== m ||
          bus.out_addr !== 16'h18A0 || bus.count !== 8'd0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b idx=%0d oh=%h addr=%h count=%0d, expected 1 10 %h 18a0 0",
                 c, bus.out_valid, bus.out_idx, bus.out_onehot, bus.out_addr, bus.count, m);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 8'd1) begin
      errors++;
      $display("FAIL backpressure_accept: valid=%b count=%0d, expected 0 1", bus.out_valid, bus.count);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 10 && !seen_done; n++) begin
      step();
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done || bus.count !== 8'd1) begin
      errors++;
      $display("FAIL backpressure_done: done_seen=%b count=%0d, expected 1 1", seen_done, bus.count);
    end
    step();
  endtask

  task automatic test_empty_full();
    logic [NB-1:0] one;
    logic [AW-1:0] exp_a;
    int            de;
    int            bad;
    one = 1;
    run_scan('0, 5'h1F, 0, '0, de);
    checks++;
    if (rec_idx.size() != 0 || de != 1 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL empty_mask: records=%0d done edge=%0d count=%0d, expected 0 1 0",
               rec_idx.size(), de, bus.count);
    end
    step();
    run_scan('1, 5'h0A, 0, '0, de);
    checks++;
    if (rec_idx.size() != 128) begin
      errors++;
      $display("FAIL full_record_count: got %0d, expected 128", rec_idx.size());
    end
    bad = 0;
    for (int i = 0; i < 128 && i < rec_idx.size(); i++) begin
      exp_a = {5'h0A, 7'(i), 4'h0};
      if (rec_idx[i] != i || rec_addr[i] !== exp_a || rec_oh[i] !== (one << i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_records: %0d of 128 records wrong, expected 0", bad);
    end
    checks++;
    if (de != 257 || bus.count !== 8'd128) begin
      errors++;
      $display("FAIL full_done: done edge=%0d count=%0d, expected edge 257 count 128", de, bus.count);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    logic [NB-1:0] m;
    logic [NB-1:0] m2;
    int            de;
    m  = '0; m[1] = 1'b1; m[2] = 1'b1;
    m2 = '0; m2[50] = 1'b1;
    run_scan(m, 5'h07, 2, m2, de);
    checks++;
    if (rec_idx.size() != 2 || de != 5 || bus.count !== 8'd2) begin
      errors++;
      $display("FAIL busy_start_ignored: records=%0d done edge=%0d count=%0d, expected 2 5 2",
               rec_idx.size(), de, bus.count);
    end else begin
      checks++;
      if (rec_idx[0] != 1 || rec_idx[1] != 2 || rec_addr[1] !== 16'h3820) begin
        errors++;
        $display("FAIL busy_start_records: idx=%0d,%0d addr1=%h, expected 1,2 3820",
                 rec_idx[0], rec_idx[1], rec_addr[1]);
      end
    end
    step();
    run_scan(m2, 5'h07, 0, '0, de);
    checks++;
    if (rec_idx.size() != 1 || de != 3) begin
      errors++;
      $display("FAIL restart_after_idle: records=%0d done edge=%0d, expected 1 3", rec_idx.size(), de);
    end else begin
      checks++;
      if (rec_idx[0] != 50 || rec_addr[0] !== 16'h3B20) begin
        errors++;
        $display("FAIL restart_record: idx=%0d addr=%h, expected 50 3b20", rec_idx[0], rec_addr[0]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] m;
    int            de;
    m = '0; m[5] = 1'b1; m[9] = 1'b1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mask_in   = m;
    bus.tag_in    = 5'h11;
    bus.out_ready = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 7'd5) begin
      errors++;
      $display("FAIL midreset_pre: valid=%b idx=%0d, expected 1 5", bus.out_valid, bus.out_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.out_idx !== '0 || bus.out_addr !== '0 || bus.out_onehot !== '0 || bus.count !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b busy=%b done=%b idx=%0d addr=%h count=%0d, all expected 0",
               bus.out_valid, bus.busy, bus.done, bus.out_idx, bus.out_addr, bus.count);
    end
    m = '0; m[7] = 1'b1;
    run_scan(m, 5'h02, 0, '0, de);
    checks++;
    if (rec_idx.size() != 1 || de != 3 || bus.count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_rescan: records=%0d done edge=%0d count=%0d, expected 1 3 1",
               rec_idx.size(), de, bus.count);
    end else begin
      checks++;
      if (rec_idx[0] != 7 || rec_addr[0] !== 16'h1070) begin
        errors++;
        $display("FAIL midreset_record: idx=%0d addr=%h, expected 7 1070", rec_idx[0], rec_addr[0]);
      end
    end
    step();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mask_in   = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sparse();
    test_back_pressure();
    test_empty_full();
    test_start_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
